// File: rtl/fft_pkg.sv
// Shared FFT datapath types: stage state encoding, default sample width and the
// butterfly scaling rule (round-half-up when SDF_ROUND_EN is defined, floor otherwise).
package fft_pkg;

  localparam int FFT_WIDTH = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } sdf_state_e;

  // Drops one LSB; callers sign-extend into 32 bits and truncate the result.
  function automatic logic signed [31:0] sdf_scale(input logic signed [31:0] v);
`ifdef SDF_ROUND_EN
    return (v + 32'sd1) >>> 1;
`else
    return v >>> 1;
`endif
  endfunction

endpackage

// File: rtl/sdf_butterfly_stage_if.sv
// Complex sample stream into and out of an SDF butterfly stage.
interface sdf_butterfly_stage_if
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH
);
  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;

  // master: upstream producer / downstream consumer side; slave: the stage itself
  modport master (output di_en, di_re, di_im, input  do_en, do_re, do_im);
  modport slave  (input  di_en, di_re, di_im, output do_en, do_re, do_im);
endinterface

// File: rtl/sdf_delay_line.sv
// M-deep feedback delay line; shifts every cycle, contents never reset.
module sdf_delay_line #(
  parameter int M  = 128,
  parameter int DW = 28
) (
  input  logic          clk,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [M-1:0][DW-1:0] sr;

  always_ff @(posedge clk) sr <= {sr[M-2:0], din};

  assign dout = sr[M-1];
endmodule

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage: frame counter, FSM,
// per-lane add/sub with feedback mux, registered output. Scaling set by SDF_ROUND_EN.
module sdf_butterfly_stage
  import fft_pkg::*;
#(
  parameter int M     = 128,
  parameter int WIDTH = FFT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  sdf_butterfly_stage_if.slave bus
);
  localparam int CW = $clog2(M) + 1;
  localparam int NL = 2;  // lane 0 = real, lane 1 = imaginary

  sdf_state_e                state;
  logic [CW-1:0]             cnt;
  logic                      half_b, take, emit;
  logic [NL-1:0][WIDTH-1:0]  din, bi, bo, cand;

  // M is a power of two, so the counter MSB marks the second half of the frame
  assign half_b = cnt[CW-1];
  assign take   = bus.di_en && (state != FLUSH);
  assign emit   = (state == RUN) || (state == FLUSH);

  assign din[0] = take ? bus.di_re : '0;
  assign din[1] = take ? bus.di_im : '0;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    logic signed [WIDTH:0] s, d;
    assign s = {bo[g][WIDTH-1], bo[g]} + {din[g][WIDTH-1], din[g]};
    assign d = {bo[g][WIDTH-1], bo[g]} - {din[g][WIDTH-1], din[g]};
    assign cand[g] = half_b ? WIDTH'(sdf_scale(32'(s))) : bo[g];
    assign bi[g]   = half_b ? WIDTH'(sdf_scale(32'(d))) : din[g];
  end

  sdf_delay_line #(.M(M), .DW(NL*WIDTH)) u_dly (
    .clk  (clk),
    .din  (bi),
    .dout (bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bus.do_en  <= 1'b0;
      bus.do_re  <= '0;
      bus.do_im  <= '0;
    end else begin
      bus.do_en <= emit;
      bus.do_re <= emit ? cand[0] : '0;
      bus.do_im <= emit ? cand[1] : '0;
      case (state)
        IDLE: if (bus.di_en) begin
          state <= FILL;
          cnt   <= cnt + 1'b1;
        end
        FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(M - 1)) state <= RUN;
        end
        RUN: begin
          // counter wraps naturally at 2M; a missing sample at a boundary ends the stream
          cnt <= cnt + 1'b1;
          if (cnt == '0 && !bus.di_en) state <= FLUSH;
        end
        FLUSH: begin
          if (cnt == CW'(M - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Bench for sdf_butterfly_stage: M=2 and M=128 instances driven by directed steps,
// checked against a frame-level butterfly model (sums then differences per frame).
module tb_sdf_butterfly_stage;
  import fft_pkg::*;

  localparam int W  = 14;
  localparam int ML = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdf_butterfly_stage_if #(.WIDTH(W)) b2 ();
  sdf_butterfly_stage_if #(.WIDTH(W)) bl ();

  sdf_butterfly_stage #(.M(2),  .WIDTH(W)) u2 (.clk(clk), .rst(rst), .bus(b2));
  sdf_butterfly_stage #(.M(ML), .WIDTH(W)) ul (.clk(clk), .rst(rst), .bus(bl));

  int nvec = 0;
  int nerr = 0;
  bit sen[$];
  int sre[$];
  int sim[$];
  int cap_re[$];

  function automatic int sc(input int v);
`ifdef SDF_ROUND_EN
    return (v + 1) >>> 1;
`else
    return v >>> 1;
`endif
  endfunction

  function automatic int xs(input int i, input int part);
    if (i >= sen.size() || !sen[i]) return 0;
    return part ? sim[i] : sre[i];
  endfunction

  function automatic int rnd();
    return int'($urandom_range(16382)) - 8191;
  endfunction

  task automatic chk(input string tag, input int t, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, $signed(obs), $signed(exp));
    end
  endtask

  task automatic push(input bit en, input int re, input int im);
    sen.push_back(en);
    sre.push_back(re);
    sim.push_back(im);
  endtask

  task automatic clear();
    sen.delete(); sre.delete(); sim.delete();
  endtask

  task automatic drive(input int sel, input logic en, input int re, input int im);
    if (sel == 0) begin
      b2.di_en = en; b2.di_re = W'(re); b2.di_im = W'(im);
    end else begin
      bl.di_en = en; bl.di_re = W'(re); bl.di_im = W'(im);
    end
  endtask

  task automatic sample(input int sel, output logic en, output logic [W-1:0] re, output logic [W-1:0] im);
    if (sel == 0) begin
      en = b2.do_en; re = b2.do_re; im = b2.do_im;
    end else begin
      en = bl.do_en; re = bl.do_re; im = bl.do_im;
    end
  endtask

  // Plays the queued stimulus into one DUT and checks every cycle against the frame model.
  task automatic run(input int sel, input int extra);
    int m, n, tot;
    int e_en[], e_re[], e_im[];
    logic oen;
    logic [W-1:0] ore, oim;
    m   = sel ? ML : 2;
    n   = sen.size();
    tot = n + extra;
    e_en = new[tot]; e_re = new[tot]; e_im = new[tot];
    for (int b = 0; b < n; b += 2 * m) begin
      if (b > 0 && !sen[b]) break;
      for (int j = 0; j < m; j++) begin
        int ar, ai, br, bi;
        ar = xs(b + j, 0);     ai = xs(b + j, 1);
        br = xs(b + m + j, 0); bi = xs(b + m + j, 1);
        if (b + m + j < tot) begin
          e_en[b+m+j] = 1; e_re[b+m+j] = sc(ar + br); e_im[b+m+j] = sc(ai + bi);
        end
        if (b + 2*m + j < tot) begin
          e_en[b+2*m+j] = 1; e_re[b+2*m+j] = sc(ar - br); e_im[b+2*m+j] = sc(ai - bi);
        end
      end
    end
    cap_re.delete();
    for (int t = 0; t < tot; t++) begin
      if (t < n) drive(sel, sen[t], sre[t], sim[t]);
      else       drive(sel, 1'b0, 0, 0);
      @(posedge clk); #1;
      sample(sel, oen, ore, oim);
      chk("do_en", t, W'(oen), W'(e_en[t]));
      if (e_en[t] != 0) begin
        chk("do_re", t, ore, W'(e_re[t]));
        chk("do_im", t, oim, W'(e_im[t]));
      end
      if (oen === 1'b1) cap_re.push_back(int'($signed(ore)));
    end
  endtask

  initial begin
    logic oen;
    logic [W-1:0] ore, oim;
    int exp_r[4];

    // reset held with random inputs on both instances
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(0, 1'($urandom_range(1)), rnd(), rnd());
      drive(1, 1'($urandom_range(1)), rnd(), rnd());
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        sample(s, oen, ore, oim);
        chk("rst_en", c, W'(oen), '0);
        chk("rst_re", c, ore, '0);
        chk("rst_im", c, oim, '0);
      end
    end
    rst = 1'b0;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        sample(s, oen, ore, oim);
        chk("idle_en", c, W'(oen), '0);
      end
    end

    // single M=2 frame, real ramp
    clear();
    for (int i = 1; i <= 4; i++) push(1'b1, i, 0);
    run(0, 6);
    exp_r = '{2, 3, -1, -1};
    chk("ramp_n", 0, W'(cap_re.size()), W'(4));
    for (int i = 0; i < 4 && i < cap_re.size(); i++) chk("ramp_re", i, W'(cap_re[i]), W'(exp_r[i]));
    chk("ramp_idle", 0, W'(u2.state), W'(IDLE));

    // scaling rule on odd sums and differences
    clear();
    push(1'b1, 1, 0); push(1'b1, 0, 0); push(1'b1, 2, 0); push(1'b1, -3, 0);
    run(0, 6);
`ifdef SDF_ROUND_EN
    exp_r = '{2, -1, 0, 2};
`else
    exp_r = '{1, -2, -1, 1};
`endif
    chk("round_n", 0, W'(cap_re.size()), W'(4));
    for (int i = 0; i < 4 && i < cap_re.size(); i++) chk("round_re", i, W'(cap_re[i]), W'(exp_r[i]));

    // three back-to-back random frames, M=128
    clear();
    for (int i = 0; i < 3 * 2 * ML; i++) push(1'b1, rnd(), rnd());
    run(1, ML + 4);
    chk("b2b_n", 0, W'(cap_re.size()), W'(6 * ML));

    // two frames with a 2-cycle di_en gap inside the second frame's half B
    clear();
    for (int i = 0; i < 2 * 2 * ML; i++) push(1'b1, rnd(), rnd());
    sen[2*ML + ML + 10] = 1'b0;
    sen[2*ML + ML + 11] = 1'b0;
    run(1, ML + 4);
    chk("drop_n", 0, W'(cap_re.size()), W'(4 * ML));
    chk("drop_idle", 0, W'(ul.state), W'(IDLE));

    // reset in RUN at cnt=M+1 on the M=2 instance
    for (int t = 0; t < 3; t++) begin
      drive(0, 1'b1, rnd(), rnd());
      @(posedge clk); #1;
    end
    drive(0, 1'b1, rnd(), rnd());
    rst = 1'b1;
    @(posedge clk); #1;
    sample(0, oen, ore, oim);
    chk("abort_en", 0, W'(oen), '0);
    chk("abort_re", 0, ore, '0);
    chk("abort_im", 0, oim, '0);
    rst = 1'b0;
    drive(0, 1'b0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    clear();
    for (int i = 0; i < 2 * 2 * 2; i++) push(1'b1, rnd(), rnd());
    run(0, 6);
    chk("fresh_n", 0, W'(cap_re.size()), W'(8));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sdf_butterfly_stage.md
# sdf_butterfly_stage

Radix-2 decimation-in-frequency single-path delay-feedback (SDF) butterfly stage for the FFT datapath. It owns the frame counter, the butterfly add/subtract and the feedback mux around a shift-register delay line of depth M. It turns a contiguous complex sample stream into the stage's butterfly outputs in SDF order, sums first and then differences. Its output feeds the twiddle-multiply stage directly downstream.

## Interface
- `M`, 128: delay-line depth, which is half the stage FFT size. Must be a power of two, at least 2.
- `WIDTH`, 14: two's-complement width of each real and imaginary component.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `di_en`  in  1  input sample valid.
- `di_re`, `di_im`  in  WIDTH  input sample, real and imaginary.
- `do_en`  out  1  output sample valid, registered.
- `do_re`, `do_im`  out  WIDTH  output sample, registered.

## Operation
- Frame length is 2M samples. The counter `cnt` runs 0..2M-1 and wraps to 0.
- Delay line:
  - Depth M, shifts every cycle, so it behaves as a pure M-cycle delay.
  - Its output is `bo`. Its input is `bi`.
- Half A (`cnt` < M):
  - `bi` = input sample. When `di_en` is low in this half, `bi` = 0.
  - Output candidate = `bo`. This is the stored scaled difference from the previous frame.
- Half B (`cnt` ≥ M), with `s` = `bo` + in and `d` = `bo` − in, both WIDTH+1 wide:
  - Output candidate = `s` scaled.
  - `bi` = `d` scaled.
- Scaling: drop one LSB from the WIDTH+1 result to get WIDTH bits.
  - Default is an arithmetic shift right by 1 (floor).
  - Overflow is impossible.
- Real and imaginary parts are processed identically and independently.
- State machine:
  - IDLE: counter held at 0, `do_en` = 0. `di_en`=1 accepts the sample at `cnt`=0 and goes to FILL.
  - FILL: first half A. No output. At `cnt`=M-1 go to RUN.
  - RUN: outputs every cycle. At `cnt`=0 (a frame boundary) with `di_en`=0, go to FLUSH. Otherwise stay in RUN.
  - FLUSH: half A with input forced to 0. It emits the last M differences. `di_en` is ignored. At `cnt`=M-1 go to IDLE.
- `do_en` = 1 for every sample emitted in RUN and in FLUSH.
- Input contract:
  - `di_en` must be contiguous for whole frames.
  - A mid-frame drop of `di_en` in FILL or RUN is not an error stop: the missing samples are treated as 0 and the frame completes.
  - FLUSH is entered only at the next boundary.
- Delay-line contents are not reset. FILL overwrites all M entries before they are read.

## Timing
- Reset values: `do_en`=0, `do_re`=0, `do_im`=0, state=IDLE, `cnt`=0.
- Reset mid-operation aborts the frame. Outputs go to their reset values on the next edge. In-flight samples are discarded.
- Latency: the input at `cnt`=M (sample x_M) produces its sum on `do_*` one cycle later.
  - So the first `do_en` comes M+1 cycles after the first accepted sample.
- Per frame, `do_en` is high for 2M consecutive cycles: M sums, then M differences, which overlap the next frame's half A.
- Back-to-back frames give a continuous `do_en` with no bubble.

## Configuration
- `SDF_ROUND_EN`
  - Defined: scaling is round-half-up, i.e. (v+1)>>>1 on the WIDTH+1 value. This can never overflow WIDTH because of the input range.
  - Undefined: floor truncation, v>>>1.
- The macro affects both the output sum and the stored difference.

## Structure
- Shared package `fft_pkg` holds:
  - the state enum (IDLE, FILL, RUN, FLUSH);
  - the scaling function;
  - the default WIDTH.
- One sub-module, `sdf_delay_line`: an M-deep, 2×WIDTH shift register. It is kept separate so it can later be mapped to RAM.
- The counter, FSM, butterfly and output register stay in the top module.

## Test plan
- Reset then idle: `rst`=1 for 3 cycles with random `di_*` → `do_en`=0 and `do_*`=0 throughout. After release with `di_en`=0, `do_en` stays 0.
- Single frame, M=2, real inputs 1,2,3,4, imaginary 0 → from 3 cycles after the first sample `do_re` = 2,3,−1,−1 with `do_en`=1 for exactly 4 cycles. State then returns to IDLE.
- Rounding, M=2, inputs 1,0,2,−3:
  - Without the macro: `do_re` = 1,−2,−1,1.
  - With `SDF_ROUND_EN`: `do_re` = 2,−1,0,2.
- Three back-to-back frames of random data, M=128 → `do_en` continuous for 768 cycles and output bit-exact against the reference model.
- `di_en` dropped for 2 cycles mid-half-B → those samples are treated as 0, the frame completes, and FLUSH occurs at the next boundary.
- `rst` asserted in RUN at `cnt`=M+1 → outputs are 0 the next cycle. A fresh frame after release gives correct results with no residue from the aborted frame.
